// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage interlock -- RAW bubbles, taken-branch IF/ID flush and halt drain.
// Keeps saturating counters of bubbles inserted and flush cycles issued.
module hazard_ctrl #(
  parameter int FLUSH_CYC = 1,
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       id_rs,
  input  logic [2:0]       id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_valid,
  input  logic [2:0]       ex_rd,
  input  logic             ex_regwrt,
  input  logic [2:0]       mem_rd,
  input  logic             mem_regwrt,
  input  logic             branch_taken,
  input  logic             halt_dec,
  output logic             NOP_mech,
  output logic             pc_stall,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_STALL  = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [2:0]       cnt_r, cnt_nxt_s;
  logic             halted_r;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
  logic             ex_hit_s, mem_hit_s, hazard_s;
  logic             nop_s, pc_stall_s, ifid_hold_s, ifid_flush_s, stall_inc_s;

  function automatic logic src_hit(input logic used, input logic [2:0] src,
                                   input logic wr, input logic [2:0] dst);
    return used & wr & (src == dst);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) begin
      return v + CNT_W'(1);
    end else begin
      return v;
    end
  endfunction

  // RAW detection against the EX and MEM writers; R0 is an ordinary register here.
  always_comb begin
    ex_hit_s  = id_valid & (src_hit(id_rs_used, id_rs, ex_regwrt, ex_rd) |
                            src_hit(id_rt_used, id_rt, ex_regwrt, ex_rd));
    mem_hit_s = id_valid & (src_hit(id_rs_used, id_rs, mem_regwrt, mem_rd) |
                            src_hit(id_rt_used, id_rt, mem_regwrt, mem_rd));
    hazard_s  = ex_hit_s | mem_hit_s;
  end

  // Next-state and countdown selection; cnt holds the cycles left in the current mode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_RUN: begin
        if (hazard_s) begin
          if (ex_hit_s) begin
            state_nxt_s = ST_STALL;
            cnt_nxt_s   = 3'd1;
          end else begin
            state_nxt_s = ST_RUN;
            cnt_nxt_s   = 3'd0;
          end
        end else if (halt_dec) begin
          if (DRAIN_CYC == 1) begin
            state_nxt_s = ST_HALTED;
            cnt_nxt_s   = 3'd0;
          end else begin
            state_nxt_s = ST_DRAIN;
            cnt_nxt_s   = 3'(DRAIN_CYC - 1);
          end
        end else if (branch_taken && (FLUSH_CYC > 1)) begin
          state_nxt_s = ST_FLUSH;
          cnt_nxt_s   = 3'(FLUSH_CYC - 1);
        end else begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = 3'd0;
        end
      end
      ST_STALL, ST_FLUSH: begin
        if (cnt_r <= 3'd1) begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = 3'd0;
        end else begin
          state_nxt_s = state_r;
          cnt_nxt_s   = cnt_r - 3'd1;
        end
      end
      ST_DRAIN: begin
        if (cnt_r <= 3'd1) begin
          state_nxt_s = ST_HALTED;
          cnt_nxt_s   = 3'd0;
        end else begin
          state_nxt_s = ST_DRAIN;
          cnt_nxt_s   = cnt_r - 3'd1;
        end
      end
      ST_HALTED: begin
        state_nxt_s = ST_HALTED;
        cnt_nxt_s   = 3'd0;
      end
      default: begin
        state_nxt_s = ST_RUN;
        cnt_nxt_s   = 3'd0;
      end
    endcase
  end

  // Pipeline controls; held low while reset is asserted so reset reads as a clean RUN.
  always_comb begin
    nop_s        = 1'b0;
    pc_stall_s   = 1'b0;
    ifid_hold_s  = 1'b0;
    ifid_flush_s = 1'b0;
    if (rst) begin
      nop_s = 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (hazard_s) begin
            nop_s       = 1'b1;
            pc_stall_s  = 1'b1;
            ifid_hold_s = 1'b1;
          end else if (halt_dec) begin
            nop_s = 1'b0;
          end else begin
            ifid_flush_s = branch_taken;
          end
        end
        ST_STALL: begin
          nop_s       = 1'b1;
          pc_stall_s  = 1'b1;
          ifid_hold_s = 1'b1;
        end
        ST_FLUSH:  ifid_flush_s = 1'b1;
        ST_DRAIN: begin
          nop_s      = 1'b1;
          pc_stall_s = 1'b1;
        end
        ST_HALTED: begin
          nop_s       = 1'b1;
          pc_stall_s  = 1'b1;
          ifid_hold_s = 1'b1;
        end
        default: nop_s = 1'b0;
      endcase
    end
    stall_inc_s = nop_s & ((state_r == ST_RUN) | (state_r == ST_STALL));
  end

  // State, countdown, sticky halt flag and saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_RUN;
      cnt_r       <= 3'd0;
      halted_r    <= 1'b0;
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      halted_r    <= (state_nxt_s == ST_HALTED);
      stall_cnt_r <= sat_inc(stall_cnt_r, stall_inc_s);
      flush_cnt_r <= sat_inc(flush_cnt_r, ifid_flush_s);
    end
  end

  assign NOP_mech    = nop_s;
  assign pc_stall    = pc_stall_s;
  assign ifid_hold   = ifid_hold_s;
  assign ifid_flush  = ifid_flush_s;
  assign halted      = halted_r;
  assign stall_count = stall_cnt_r;
  assign flush_count = flush_cnt_r;

endmodule
